// File: rtl/fetch_request_sequencer.sv
// Fetch request sequencer: single-line buffer in front of a one-outstanding-request memory port.
// Hits return in one cycle; misses go out as a held request and fill the buffer on response.
module fetch_request_sequencer (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic         invalidate,
  input  logic [31:0]  fetchAddress,
  output logic [127:0] fetchData,
  output logic         fetchDataValid,
  output logic [31:0]  fetchDataAddress,
  output logic         memRequest,
  output logic [31:0]  memAddress,
  input  logic         memGrant,
  input  logic         memResponseValid,
  input  logic [127:0] memResponseData,
  output logic         busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRequest = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StDrain   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         squash_q, squash_d;
  logic         line_valid_q, line_valid_d;
  logic [27:0]  line_tag_q, line_tag_d;
  logic [127:0] line_data_q, line_data_d;
  logic         mem_request_q, mem_request_d;
  logic [27:0]  mem_address_q, mem_address_d;
  logic         fetch_data_valid_q, fetch_data_valid_d;
  logic [127:0] fetch_data_q, fetch_data_d;
  logic [27:0]  fetch_data_address_q, fetch_data_address_d;

  logic hit;
  logic unused_addr_bits;

  assign unused_addr_bits = ^fetchAddress[3:0];

  // A lookup coinciding with invalidate must not hit the line being cleared.
  assign hit = line_valid_q && (fetchAddress[31:4] == line_tag_q) && !invalidate;

  always_comb begin
    state_d              = state_q;
    squash_d             = squash_q;
    line_valid_d         = line_valid_q;
    line_tag_d           = line_tag_q;
    line_data_d          = line_data_q;
    mem_request_d        = mem_request_q;
    mem_address_d        = mem_address_q;
    fetch_data_valid_d   = 1'b0;
    fetch_data_d         = fetch_data_q;
    fetch_data_address_d = fetch_data_address_q;

    case (state_q)
      StIdle: begin
        if (!redirect) begin
          if (hit) begin
            fetch_data_valid_d   = 1'b1;
            fetch_data_d         = line_data_q;
            fetch_data_address_d = line_tag_q;
          end else begin
            mem_address_d = fetchAddress[31:4];
            mem_request_d = 1'b1;
            squash_d      = 1'b0;
            state_d       = StRequest;
          end
        end
      end
      StRequest: begin
        if (redirect) begin
          squash_d = 1'b1;
        end
        if (memGrant) begin
          mem_request_d = 1'b0;
          squash_d      = 1'b0;
          state_d       = (squash_q || redirect) ? StDrain : StWait;
        end
      end
      StWait: begin
        if (memResponseValid) begin
          // The fill still lands on a redirect; only the output pulse is dropped.
          line_valid_d = 1'b1;
          line_tag_d   = mem_address_q;
          line_data_d  = memResponseData;
          if (!redirect) begin
            fetch_data_valid_d   = 1'b1;
            fetch_data_d         = memResponseData;
            fetch_data_address_d = mem_address_q;
          end
          state_d = StIdle;
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (memResponseValid) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (invalidate) begin
      line_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= StIdle;
      squash_q             <= 1'b0;
      line_valid_q         <= 1'b0;
      line_tag_q           <= '0;
      line_data_q          <= '0;
      mem_request_q        <= 1'b0;
      mem_address_q        <= '0;
      fetch_data_valid_q   <= 1'b0;
      fetch_data_q         <= '0;
      fetch_data_address_q <= '0;
    end else begin
      state_q              <= state_d;
      squash_q             <= squash_d;
      line_valid_q         <= line_valid_d;
      line_tag_q           <= line_tag_d;
      line_data_q          <= line_data_d;
      mem_request_q        <= mem_request_d;
      mem_address_q        <= mem_address_d;
      fetch_data_valid_q   <= fetch_data_valid_d;
      fetch_data_q         <= fetch_data_d;
      fetch_data_address_q <= fetch_data_address_d;
    end
  end

  assign fetchData        = fetch_data_q;
  assign fetchDataValid   = fetch_data_valid_q;
  assign fetchDataAddress = {fetch_data_address_q, 4'h0};
  assign memRequest       = mem_request_q;
  assign memAddress       = {mem_address_q, 4'h0};
  assign busy             = (state_q != StIdle);

endmodule
